// File: rtl/pipe_hazard_unit_pkg.sv
// Shared definitions for the hazard/forwarding controller: forwarding select
// codes, scoreboard entry layout and pipeline advance modes.
package pipe_hazard_unit_pkg;

  // ID-stage operand source (branch compare / jr)
  typedef enum logic [1:0] {
    FWD_ID_RF  = 2'b00,
    FWD_ID_EX  = 2'b01,
    FWD_ID_MEM = 2'b10,
    FWD_ID_WB  = 2'b11
  } fwdIdSel_e;

  // EX-stage operand source
  typedef enum logic [1:0] {
    FWD_EX_BUS = 2'b00,
    FWD_EX_WB  = 2'b01,
    FWD_EX_MEM = 2'b10
  } fwdExSel_e;

  // How the EX/MEM/WB scoreboard moves on a clock
  typedef enum logic [1:0] {
    ADV_RUN       = 2'b00,
    ADV_BUBBLE_EX = 2'b01,
    ADV_HOLD_EX   = 2'b10
  } advMode_e;

  // Scoreboard stage indices
  localparam int unsigned ST_EX  = 0;
  localparam int unsigned ST_MEM = 1;
  localparam int unsigned ST_WB  = 2;
  localparam int unsigned NUM_ST = 3;

  // Entry layout, MSB first: {v, wr, rw[aw-1:0], ld}
  localparam int unsigned SB_LD     = 0;
  localparam int unsigned SB_RW_LSB = 1;

  function automatic int unsigned sbRwMsb(input int unsigned aw);
    return aw;
  endfunction

  function automatic int unsigned sbWrBit(input int unsigned aw);
    return aw + 1;
  endfunction

  function automatic int unsigned sbVBit(input int unsigned aw);
    return aw + 2;
  endfunction

  function automatic int unsigned sbWidth(input int unsigned aw);
    return aw + 3;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_match.sv
// hz_match: does a scoreboard entry produce a value this source reads?
// ldOk = 0 rejects entries whose result comes from a load.
module hz_match
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [sbWidth(REG_AW)-1:0] entry,
  input  logic [REG_AW-1:0]          src,
  input  logic                       used,
  input  logic                       ldOk,
  output logic                       hit
);

  localparam int unsigned V_BIT  = sbVBit(REG_AW);
  localparam int unsigned WR_BIT = sbWrBit(REG_AW);
  localparam int unsigned RW_MSB = sbRwMsb(REG_AW);

  // Register 0 never matches: it is hardwired zero
  always_comb begin
    hit = entry[V_BIT] & entry[WR_BIT] & used & (src != '0)
        & (entry[RW_MSB:SB_RW_LSB] == src)
        & (ldOk | ~entry[SB_LD]);
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage core. Tracks EX/MEM/WB
// destinations, drives ID and EX forwarding selects, stalls for load-use,
// early-branch-on-load and multi-cycle mul/div, and flushes IF/ID on redirect.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_early,
  input  logic              id_wr,
  input  logic [REG_AW-1:0] id_rw,
  input  logic              id_is_load,
  input  logic              id_is_md,
  input  logic              id_redirect,
  output logic              pc_wr,
  output logic              if_id_wr,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              ex_mem_bubble,
  output logic [1:0]        fwd_id_a,
  output logic [1:0]        fwd_id_b,
  output logic [1:0]        fwd_ex_a,
  output logic [1:0]        fwd_ex_b,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned    SBW     = sbWidth(REG_AW);
  localparam int unsigned    MDW     = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [MDW-1:0] MD_INIT = MDW'(MD_LAT - 1);

  // Scoreboard state
  logic [SBW-1:0]    sbEx;
  logic [SBW-1:0]    sbMem;
  logic [SBW-1:0]    sbWb;
  logic [REG_AW-1:0] exRs;
  logic [REG_AW-1:0] exRt;
  logic              exRsUsed;
  logic              exRtUsed;
  logic [MDW-1:0]    mdCnt;
  logic [CNT_W-1:0]  stallCntQ;

  logic [SBW-1:0]    sbStage [NUM_ST];
  logic [NUM_ST-1:0] idHitA;
  logic [NUM_ST-1:0] idHitB;
  logic              memAluHitExA;
  logic              memAluHitExB;
  logic              wbHitExA;
  logic              wbHitExB;

  logic              mdBusy;
  logic              exLd;
  logic              memLd;
  logic              lu;
  logic              eu;
  logic              stall;
  advMode_e          advMode;

  assign sbStage[ST_EX]  = sbEx;
  assign sbStage[ST_MEM] = sbMem;
  assign sbStage[ST_WB]  = sbWb;

  // ID sources against every in-flight stage; load-ness is resolved below
  for (genvar st = 0; st < NUM_ST; st++) begin : gIdMatch
    hz_match #(.REG_AW(REG_AW)) uMatchA (
      .entry (sbStage[st]),
      .src   (id_rs),
      .used  (id_rs_used),
      .ldOk  (1'b1),
      .hit   (idHitA[st])
    );
    hz_match #(.REG_AW(REG_AW)) uMatchB (
      .entry (sbStage[st]),
      .src   (id_rt),
      .used  (id_rt_used),
      .ldOk  (1'b1),
      .hit   (idHitB[st])
    );
  end

  // EX sources: a MEM load never forwards from MEM, it is picked up from WB
  hz_match #(.REG_AW(REG_AW)) uExMemA (
    .entry (sbMem),
    .src   (exRs),
    .used  (exRsUsed),
    .ldOk  (1'b0),
    .hit   (memAluHitExA)
  );
  hz_match #(.REG_AW(REG_AW)) uExMemB (
    .entry (sbMem),
    .src   (exRt),
    .used  (exRtUsed),
    .ldOk  (1'b0),
    .hit   (memAluHitExB)
  );
  hz_match #(.REG_AW(REG_AW)) uExWbA (
    .entry (sbWb),
    .src   (exRs),
    .used  (exRsUsed),
    .ldOk  (1'b1),
    .hit   (wbHitExA)
  );
  hz_match #(.REG_AW(REG_AW)) uExWbB (
    .entry (sbWb),
    .src   (exRt),
    .used  (exRtUsed),
    .ldOk  (1'b1),
    .hit   (wbHitExB)
  );

  // Nearest producer wins; an EX load has no value yet so it is skipped
  function automatic fwdIdSel_e pickIdFwd(input logic early, input logic exHit,
                                          input logic exIsLd, input logic memHit,
                                          input logic wbHit);
    if (!early)               return FWD_ID_RF;
    if (exHit && !exIsLd)     return FWD_ID_EX;
    if (memHit)               return FWD_ID_MEM;
    if (wbHit)                return FWD_ID_WB;
    return FWD_ID_RF;
  endfunction

  function automatic fwdExSel_e pickExFwd(input logic memAluHit, input logic wbHit);
    if (memAluHit) return FWD_EX_MEM;
    if (wbHit)     return FWD_EX_WB;
    return FWD_EX_BUS;
  endfunction

  // Stall detection: mul/div occupancy, load-use, early consumer behind EX-then-MEM-load
  always_comb begin
    mdBusy = (mdCnt != '0);
    exLd   = sbEx[SB_LD];
    memLd  = sbMem[SB_LD];
    lu     = (idHitA[ST_EX] | idHitB[ST_EX]) & exLd;
    eu     = id_early & ((idHitA[ST_EX] & ~exLd & idHitA[ST_MEM] & memLd)
                       | (idHitB[ST_EX] & ~exLd & idHitB[ST_MEM] & memLd));
    stall  = mdBusy | lu | eu;
  end

  // Pick how the scoreboard advances this cycle
  always_comb begin
    advMode = ADV_RUN;
    if (mdBusy) begin
      advMode = ADV_HOLD_EX;
    end else if (lu | eu) begin
      advMode = ADV_BUBBLE_EX;
    end
  end

  // Control outputs; everything forced quiet while rst is high
  always_comb begin
    pc_wr         = 1'b0;
    if_id_wr      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    fwd_id_a      = FWD_ID_RF;
    fwd_id_b      = FWD_ID_RF;
    fwd_ex_a      = FWD_EX_BUS;
    fwd_ex_b      = FWD_EX_BUS;
    stall_cnt     = '0;
    if (!rst) begin
      pc_wr         = ~stall;
      if_id_wr      = ~stall;
      // A stalled redirect stays in ID and is taken once the stall clears
      if_id_flush   = id_valid & id_redirect & ~stall;
      id_ex_bubble  = ~mdBusy & (lu | eu);
      ex_mem_bubble = mdBusy;
      fwd_id_a      = pickIdFwd(id_early, idHitA[ST_EX], exLd, idHitA[ST_MEM], idHitA[ST_WB]);
      fwd_id_b      = pickIdFwd(id_early, idHitB[ST_EX], exLd, idHitB[ST_MEM], idHitB[ST_WB]);
      fwd_ex_a      = pickExFwd(memAluHitExA, wbHitExA);
      fwd_ex_b      = pickExFwd(memAluHitExB, wbHitExB);
      stall_cnt     = stallCntQ;
    end
  end

  // Scoreboard advance
  always_ff @(posedge clk) begin
    if (rst) begin
      sbEx     <= '0;
      sbMem    <= '0;
      sbWb     <= '0;
      exRs     <= '0;
      exRt     <= '0;
      exRsUsed <= 1'b0;
      exRtUsed <= 1'b0;
    end else begin
      case (advMode)
        ADV_HOLD_EX: begin
          sbMem <= '0;
          sbWb  <= sbMem;
        end
        ADV_BUBBLE_EX: begin
          sbEx     <= '0;
          exRs     <= '0;
          exRt     <= '0;
          exRsUsed <= 1'b0;
          exRtUsed <= 1'b0;
          sbMem    <= sbEx;
          sbWb     <= sbMem;
        end
        default: begin
          sbEx     <= {id_valid, id_wr, id_rw, id_is_load};
          exRs     <= id_rs;
          exRt     <= id_rt;
          exRsUsed <= id_rs_used;
          exRtUsed <= id_rt_used;
          sbMem    <= sbEx;
          sbWb     <= sbMem;
        end
      endcase
    end
  end

  // Mul/div occupancy: armed when a mul/div enters EX, counts down to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      mdCnt <= '0;
    end else if (mdBusy) begin
      mdCnt <= mdCnt - MDW'(1);
    end else if (advMode == ADV_RUN && id_valid && id_is_md) begin
      mdCnt <= MD_INIT;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCntQ <= '0;
    end else if (stall && stallCntQ != '1) begin
      stallCntQ <= stallCntQ + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed scenarios plus randomized traffic
// checked against an instruction-level pipeline model.
module tb_pipe_hazard_unit;

  localparam int unsigned MDL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_early, id_wr;
  logic       id_is_load, id_is_md, id_redirect;
  logic [4:0] id_rs, id_rt, id_rw;

  logic        pcWr, ifIdWr, flush, idExB, exMemB;
  logic [1:0]  fIdA, fIdB, fExA, fExB;
  logic [15:0] sCnt;
  logic        sPcWr, sIfIdWr, sFlush, sIdExB, sExMemB;
  logic [1:0]  sFIdA, sFIdB, sFExA, sFExB;
  logic [1:0]  sCnt2;

  pipe_hazard_unit #(.REG_AW(5), .MD_LAT(MDL), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_early(id_early),
    .id_wr(id_wr), .id_rw(id_rw), .id_is_load(id_is_load), .id_is_md(id_is_md),
    .id_redirect(id_redirect), .pc_wr(pcWr), .if_id_wr(ifIdWr),
    .if_id_flush(flush), .id_ex_bubble(idExB), .ex_mem_bubble(exMemB),
    .fwd_id_a(fIdA), .fwd_id_b(fIdB), .fwd_ex_a(fExA), .fwd_ex_b(fExB),
    .stall_cnt(sCnt)
  );

  pipe_hazard_unit #(.REG_AW(5), .MD_LAT(MDL), .CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_early(id_early),
    .id_wr(id_wr), .id_rw(id_rw), .id_is_load(id_is_load), .id_is_md(id_is_md),
    .id_redirect(id_redirect), .pc_wr(sPcWr), .if_id_wr(sIfIdWr),
    .if_id_flush(sFlush), .id_ex_bubble(sIdExB), .ex_mem_bubble(sExMemB),
    .fwd_id_a(sFIdA), .fwd_id_b(sFIdB), .fwd_ex_a(sFExA), .fwd_ex_b(sFExB),
    .stall_cnt(sCnt2)
  );

  int nChecks = 0;
  int nFails  = 0;

  // Instruction-level model of what sits in EX/MEM/WB
  typedef struct packed {
    logic       v;
    logic       wr;
    logic [4:0] rw;
    logic       ld;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rsU;
    logic       rtU;
  } ins_t;

  ins_t        mEx, mMem, mWb;
  int unsigned mMd;
  int unsigned mStalls;
  logic        eMdBusy, eHaz, eStall;
  logic [1:0]  eFIdA, eFIdB, eFExA, eFExB;

  function automatic bit produces(ins_t e, logic [4:0] src, logic used);
    return e.v && e.wr && used && src != 5'd0 && e.rw == src;
  endfunction

  function automatic logic [1:0] idSel(logic [4:0] src, logic used);
    if (!id_early) return 2'd0;
    if (produces(mEx, src, used) && !mEx.ld) return 2'd1;
    if (produces(mMem, src, used)) return 2'd2;
    if (produces(mWb, src, used)) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [1:0] exSel(logic [4:0] src, logic used);
    if (produces(mMem, src, used) && !mMem.ld) return 2'd2;
    if (produces(mWb, src, used)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic void modelEval();
    bit lu, eu;
    lu = (produces(mEx, id_rs, id_rs_used) || produces(mEx, id_rt, id_rt_used)) && mEx.ld;
    eu = id_early && !mEx.ld && mMem.ld &&
         ((produces(mEx, id_rs, id_rs_used) && produces(mMem, id_rs, id_rs_used)) ||
          (produces(mEx, id_rt, id_rt_used) && produces(mMem, id_rt, id_rt_used)));
    eMdBusy = (mMd != 0);
    eHaz    = lu || eu;
    eStall  = eMdBusy || eHaz;
    eFIdA   = idSel(id_rs, id_rs_used);
    eFIdB   = idSel(id_rt, id_rt_used);
    eFExA   = exSel(mEx.rs, mEx.rsU);
    eFExB   = exSel(mEx.rt, mEx.rtU);
  endfunction

  // One clock: evaluate model with current inputs, clock, advance model
  task automatic tick();
    ins_t idIns;
    modelEval();
    idIns = '{v:id_valid, wr:id_wr, rw:id_rw, ld:id_is_load, rs:id_rs, rt:id_rt,
              rsU:id_rs_used, rtU:id_rt_used};
    @(posedge clk);
    if (rst) begin
      mEx = '0; mMem = '0; mWb = '0; mMd = 0; mStalls = 0;
    end else begin
      if (eStall) mStalls++;
      if (eMdBusy) begin
        mWb = mMem; mMem = '0; mMd--;
      end else if (eHaz) begin
        mWb = mMem; mMem = mEx; mEx = '0;
      end else begin
        mWb = mMem; mMem = mEx; mEx = idIns;
        if (id_valid && id_is_md) mMd = MDL - 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic setId(input logic v, input logic [4:0] rs, input logic rsU,
                       input logic [4:0] rt, input logic rtU, input logic early,
                       input logic wr, input logic [4:0] rw, input logic ld,
                       input logic md, input logic redir);
    id_valid = v; id_rs = rs; id_rs_used = rsU; id_rt = rt; id_rt_used = rtU;
    id_early = early; id_wr = wr; id_rw = rw; id_is_load = ld; id_is_md = md;
    id_redirect = redir;
    #1;
  endtask

  task automatic idle();
    setId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    rst = 1'b1; idle();
    tick(); tick();
    rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    setId(1, 5'd3, 1, 5'd4, 1, 1, 1, 5'd3, 1, 1, 1);
    nChecks++;
    if ({pcWr, ifIdWr, flush, idExB, exMemB, fIdA, fIdB, fExA, fExB, sCnt} !== '0) begin
      nFails++; $display("FAIL reset_outputs: got pc_wr=%b if_id_wr=%b flush=%b cnt=%0d, want all 0",
                         pcWr, ifIdWr, flush, sCnt);
    end
    tick(); tick();
    rst = 1'b0; idle();
    nChecks++;
    if ({pcWr, ifIdWr, exMemB, idExB, sCnt} !== {1'b1, 1'b1, 1'b0, 1'b0, 16'd0}) begin
      nFails++; $display("FAIL reset_release: got pc_wr=%b if_id_wr=%b ex_mem_bubble=%b cnt=%0d, want 1 1 0 0",
                         pcWr, ifIdWr, exMemB, sCnt);
    end
  endtask

  task automatic test_load_use();
    doReset();
    setId(1, 5'd1, 1, 5'd0, 0, 0, 1, 5'd2, 1, 0, 0);   // lw r2,0(r1)
    tick();
    setId(1, 5'd2, 1, 5'd4, 1, 0, 1, 5'd3, 0, 0, 0);   // add r3,r2,r4
    nChecks++;
    if ({pcWr, ifIdWr, idExB} !== 3'b001) begin
      nFails++; $display("FAIL load_use_stall: got pc_wr/if_id_wr/id_ex_bubble=%b, want 001", {pcWr, ifIdWr, idExB});
    end
    tick();
    nChecks++;
    if ({pcWr, idExB, sCnt} !== {1'b1, 1'b0, 16'd1}) begin
      nFails++; $display("FAIL load_use_release: got pc_wr=%b bubble=%b cnt=%0d, want 1 0 1", pcWr, idExB, sCnt);
    end
    tick();
    idle();
    nChecks++;
    if ({fExA, fExB, sCnt} !== {2'b01, 2'b00, 16'd1}) begin
      nFails++; $display("FAIL load_use_fwd: got fwd_ex_a=%b fwd_ex_b=%b cnt=%0d, want 01 00 1", fExA, fExB, sCnt);
    end
  endtask

  task automatic test_alu_chain();
    doReset();
    setId(1, 5'd2, 1, 5'd3, 1, 0, 1, 5'd1, 0, 0, 0);   // add r1,r2,r3
    tick();
    setId(1, 5'd1, 1, 5'd0, 1, 0, 1, 5'd2, 0, 0, 0);   // add r2,r1,r0
    nChecks++;
    if ({pcWr, idExB} !== 2'b10) begin
      nFails++; $display("FAIL alu_chain_nostall: got pc_wr=%b bubble=%b, want 1 0", pcWr, idExB);
    end
    tick();
    setId(1, 5'd0, 1, 5'd1, 1, 0, 1, 5'd4, 0, 0, 0);   // sub r4,r0,r1
    nChecks++;
    if ({fExA, fExB, pcWr} !== {2'b10, 2'b00, 1'b1}) begin
      nFails++; $display("FAIL alu_chain_mem: got fwd_ex_a=%b fwd_ex_b=%b pc_wr=%b, want 10 00 1", fExA, fExB, pcWr);
    end
    tick();
    idle();
    nChecks++;
    if ({fExA, fExB} !== {2'b00, 2'b01}) begin
      nFails++; $display("FAIL alu_chain_wb: got fwd_ex_a=%b fwd_ex_b=%b, want 00 01", fExA, fExB);
    end
  endtask

  task automatic test_branch();
    doReset();
    setId(1, 5'd1, 1, 5'd2, 1, 0, 1, 5'd5, 0, 0, 0);   // add r5,r1,r2
    tick();
    setId(1, 5'd5, 1, 5'd0, 1, 1, 0, 5'd0, 0, 0, 1);   // beq r5,r0 taken
    nChecks++;
    if ({fIdA, fIdB, flush, pcWr} !== {2'b01, 2'b00, 1'b1, 1'b1}) begin
      nFails++; $display("FAIL branch_ex_fwd: got fwd_id_a=%b fwd_id_b=%b flush=%b pc_wr=%b, want 01 00 1 1",
                         fIdA, fIdB, flush, pcWr);
    end
    tick();
    setId(1, 5'd1, 1, 5'd0, 0, 0, 1, 5'd5, 1, 0, 0);   // lw r5,0(r1)
    tick();
    setId(1, 5'd5, 1, 5'd0, 1, 1, 0, 5'd0, 0, 0, 1);   // beq r5,r0 taken
    nChecks++;
    if ({pcWr, idExB, flush} !== 3'b010) begin
      nFails++; $display("FAIL branch_load_stall: got pc_wr=%b bubble=%b flush=%b, want 0 1 0", pcWr, idExB, flush);
    end
    tick();
    nChecks++;
    if ({fIdA, flush, pcWr} !== {2'b10, 1'b1, 1'b1}) begin
      nFails++; $display("FAIL branch_load_fwd: got fwd_id_a=%b flush=%b pc_wr=%b, want 10 1 1", fIdA, flush, pcWr);
    end
  endtask

  task automatic test_muldiv();
    doReset();
    setId(1, 5'd1, 1, 5'd2, 1, 0, 1, 5'd7, 0, 1, 0);   // mult
    tick();
    setId(1, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1);   // j target
    for (int unsigned c = 0; c < MDL - 1; c++) begin
      nChecks++;
      if ({exMemB, pcWr, ifIdWr, flush, idExB} !== 5'b10000) begin
        nFails++; $display("FAIL muldiv_stall[%0d]: got ex_mem_bubble/pc_wr/if_id_wr/flush/id_ex_bubble=%b, want 10000",
                           c, {exMemB, pcWr, ifIdWr, flush, idExB});
      end
      tick();
    end
    nChecks++;
    if ({exMemB, pcWr, flush, sCnt} !== {1'b0, 1'b1, 1'b1, 16'd3}) begin
      nFails++; $display("FAIL muldiv_release: got ex_mem_bubble=%b pc_wr=%b flush=%b cnt=%0d, want 0 1 1 3",
                         exMemB, pcWr, flush, sCnt);
    end
    tick();
    idle();
  endtask

  task automatic test_reg_zero_and_sat();
    doReset();
    setId(1, 5'd1, 1, 5'd0, 0, 0, 1, 5'd0, 1, 0, 0);   // lw r0
    tick();
    setId(1, 5'd0, 1, 5'd0, 1, 1, 1, 5'd1, 0, 0, 0);   // add r1,r0,r0 (early read too)
    nChecks++;
    if ({pcWr, idExB, fIdA, fIdB} !== {1'b1, 1'b0, 4'b0000}) begin
      nFails++; $display("FAIL reg0_id: got pc_wr=%b bubble=%b fwd_id=%b%b, want 1 0 0000", pcWr, idExB, fIdA, fIdB);
    end
    tick();
    idle();
    nChecks++;
    if ({fExA, fExB} !== 4'b0000) begin
      nFails++; $display("FAIL reg0_ex: got fwd_ex=%b%b, want 0000", fExA, fExB);
    end
    // 3 mul/div stall cycles followed by two load-use stalls
    doReset();
    setId(1, 5'd1, 1, 5'd2, 1, 0, 1, 5'd9, 0, 1, 0);
    tick();
    idle();
    tick(); tick(); tick();
    setId(1, 5'd1, 1, 5'd0, 0, 0, 1, 5'd2, 1, 0, 0);
    tick();
    setId(1, 5'd2, 1, 5'd0, 0, 0, 1, 5'd6, 0, 0, 0);
    tick(); tick();
    setId(1, 5'd1, 1, 5'd0, 0, 0, 1, 5'd3, 1, 0, 0);
    tick();
    setId(1, 5'd3, 1, 5'd0, 0, 0, 1, 5'd8, 0, 0, 0);
    tick(); tick();
    idle();
    nChecks++;
    if ({sCnt2, sCnt} !== {2'd3, 16'd5}) begin
      nFails++; $display("FAIL stall_cnt_sat: got narrow=%0d wide=%0d, want 3 5", sCnt2, sCnt);
    end
  endtask

  task automatic test_reset_mid_md();
    doReset();
    setId(1, 5'd1, 1, 5'd2, 1, 0, 1, 5'd7, 0, 1, 0);   // mult r7
    tick();
    idle();
    tick();
    rst = 1'b1; #1;
    nChecks++;
    if ({pcWr, ifIdWr, exMemB, idExB, flush, sCnt} !== '0) begin
      nFails++; $display("FAIL rst_mid_md_hold: got pc_wr=%b ex_mem_bubble=%b cnt=%0d, want all 0", pcWr, exMemB, sCnt);
    end
    tick();
    rst = 1'b0;
    setId(1, 5'd7, 1, 5'd0, 0, 1, 0, 5'd0, 0, 0, 0);   // early reader of r7
    nChecks++;
    if ({exMemB, pcWr, idExB, fIdA, sCnt} !== {1'b0, 1'b1, 1'b0, 2'b00, 16'd0}) begin
      nFails++; $display("FAIL rst_mid_md_clear: got ex_mem_bubble=%b pc_wr=%b bubble=%b fwd_id_a=%b cnt=%0d, want 0 1 0 00 0",
                         exMemB, pcWr, idExB, fIdA, sCnt);
    end
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [4:0]  expCtl;
    logic [7:0]  expFwd;
    logic [15:0] expCnt;
    logic [1:0]  expCnt2;
    doReset();
    for (int unsigned i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      setId(1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      modelEval();
      if (rst) begin
        expCtl = '0; expFwd = '0; expCnt = '0; expCnt2 = '0;
      end else begin
        expCtl  = {~eStall, ~eStall, id_valid & id_redirect & ~eStall, ~eMdBusy & eHaz, eMdBusy};
        expFwd  = {eFIdA, eFIdB, eFExA, eFExB};
        expCnt  = (mStalls > 65535) ? 16'hFFFF : 16'(mStalls);
        expCnt2 = (mStalls > 3) ? 2'd3 : 2'(mStalls);
      end
      nChecks++;
      if ({pcWr, ifIdWr, flush, idExB, exMemB} !== expCtl) begin
        nFails++; $display("FAIL rand_ctl[%0d]: got %b want %b", i, {pcWr, ifIdWr, flush, idExB, exMemB}, expCtl);
      end
      nChecks++;
      if ({fIdA, fIdB, fExA, fExB} !== expFwd) begin
        nFails++; $display("FAIL rand_fwd[%0d]: got %b want %b", i, {fIdA, fIdB, fExA, fExB}, expFwd);
      end
      nChecks++;
      if ({sCnt, sCnt2} !== {expCnt, expCnt2}) begin
        nFails++; $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", i, sCnt, sCnt2, expCnt, expCnt2);
      end
      nChecks++;
      if ({sPcWr, sIfIdWr, sFlush, sIdExB, sExMemB, sFIdA, sFIdB, sFExA, sFExB} !== {expCtl, expFwd}) begin
        nFails++; $display("FAIL rand_narrow[%0d]: got %b want %b", i,
                           {sPcWr, sIfIdWr, sFlush, sIdExB, sExMemB, sFIdA, sFIdB, sFExA, sFExB}, {expCtl, expFwd});
      end
      tick();
    end
  endtask

  initial begin
    mEx = '0; mMem = '0; mWb = '0; mMd = 0; mStalls = 0;
    rst = 1'b1;
    #2;
    test_reset();
    test_load_use();
    test_alu_chain();
    test_branch();
    test_muldiv();
    test_reg_zero_and_sat();
    test_reset_mid_md();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
